lake_cfg_loader: RTL and testbench

- Config-bus responder in front of lakespec. Receives 32-bit word-addressed config writes and reads from the tile configuration initiator, and assembles them into the 550-bit config_memory_size_550 vector.
- Double-buffered: writes land in a shadow register. An explicit commit copies shadow to the active vector that drives lakespec.
- The copy is deferred while stall is high, so the accelerator never sees a partially written configuration.

---
 rtl/lake_cfg_loader_pkg.sv | 23 ++
 rtl/lake_cfg_loader_if.sv | 23 ++
 rtl/lake_cfg_loader.sv | 116 +++++++++++
 tb/tb_lake_cfg_loader.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/lake_cfg_loader_pkg.sv
// Shared constants for the lakespec configuration loader: widths, word count,
// the address map and the STATUS register bit layout.
package lake_cfg_pkg;

    localparam int CFG_WIDTH     = 550;
    localparam int BUS_WIDTH     = 32;
    localparam int ADDR_WIDTH    = 32;
    localparam int NUM_WORDS     = (CFG_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH;
    localparam int TOP_WORD_BITS = CFG_WIDTH - (NUM_WORDS - 1) * BUS_WIDTH;
    localparam int WIDX_W        = $clog2(NUM_WORDS);

    localparam int CFG_ADDR_COMMIT = 18;
    localparam int CFG_ADDR_STATUS = 19;

    localparam int STAT_PENDING = 0;
    localparam int STAT_ERR     = 1;
    localparam int STAT_VALID   = 2;

    // The top shadow word only carries the leftover bits of the vector.
    localparam logic [BUS_WIDTH-1:0] TOP_WORD_MASK =
        {{(BUS_WIDTH - TOP_WORD_BITS){1'b0}}, {TOP_WORD_BITS{1'b1}}};

endpackage

// File: rtl/lake_cfg_loader_if.sv
// Word-addressed config bus between the tile configuration initiator (master)
// and the loader (slave).
interface lake_cfg_if;
    import lake_cfg_pkg::*;

    logic [ADDR_WIDTH-1:0] config_config_addr;
    logic [BUS_WIDTH-1:0]  config_config_data;
    logic                  config_write;
    logic                  config_read;
    logic [BUS_WIDTH-1:0]  config_rd_data;
    logic                  config_rd_valid;

    modport master (
        output config_config_addr, config_config_data, config_write, config_read,
        input  config_rd_data, config_rd_valid
    );

    modport slave (
        input  config_config_addr, config_config_data, config_write, config_read,
        output config_rd_data, config_rd_valid
    );

endinterface

// File: rtl/lake_cfg_loader.sv
// Double-buffered configuration loader: bus writes fill a shadow copy, and a
// commit (deferred while stalled) loads the active vector driving lakespec.
module lake_cfg_loader
    import lake_cfg_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    lake_cfg_if.slave            cfg_bus,
    output logic [CFG_WIDTH-1:0] config_memory_size_550,
    output logic                 cfg_valid,
    output logic                 cfg_update,
    output logic                 cfg_err
);

    logic [BUS_WIDTH-1:0]  shadow_reg [NUM_WORDS];
    logic [CFG_WIDTH-1:0]  shadow_flat;
    logic [CFG_WIDTH-1:0]  active_reg;
    logic [BUS_WIDTH-1:0]  rd_data_reg;
    logic                  rd_valid_reg;
    logic                  pending_reg;
    logic                  valid_reg;
    logic                  update_reg;
    logic                  err_reg;

    logic [ADDR_WIDTH-1:0] addr;
    logic [WIDX_W-1:0]     widx;
    logic                  is_word;
    logic                  is_commit;
    logic                  is_status;
    logic                  is_oor;
    logic                  do_copy;
    logic [BUS_WIDTH-1:0]  wr_word;
    logic [BUS_WIDTH-1:0]  rd_mux;
    logic [BUS_WIDTH-1:0]  status_word;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WORDS - 1; gi++) begin : g_flat
            assign shadow_flat[gi*BUS_WIDTH +: BUS_WIDTH] = shadow_reg[gi];
        end
    endgenerate
    assign shadow_flat[CFG_WIDTH-1 -: TOP_WORD_BITS] =
        shadow_reg[NUM_WORDS-1][TOP_WORD_BITS-1:0];

    assign addr      = cfg_bus.config_config_addr;
    assign widx      = addr[WIDX_W-1:0];
    assign is_word   = addr < ADDR_WIDTH'(NUM_WORDS);
    assign is_commit = addr == ADDR_WIDTH'(CFG_ADDR_COMMIT);
    assign is_status = addr == ADDR_WIDTH'(CFG_ADDR_STATUS);
    assign is_oor    = addr > ADDR_WIDTH'(CFG_ADDR_STATUS);
    assign do_copy   = pending_reg && !stall;

    always_comb begin
        status_word               = '0;
        status_word[STAT_PENDING] = pending_reg;
        status_word[STAT_ERR]     = err_reg;
        status_word[STAT_VALID]   = valid_reg;

        wr_word = cfg_bus.config_config_data;
        if (widx == WIDX_W'(NUM_WORDS - 1))
            wr_word = cfg_bus.config_config_data & TOP_WORD_MASK;

        rd_mux = '0;
        if (is_word)
            rd_mux = shadow_reg[widx];
        else if (is_status)
            rd_mux = status_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_WORDS; i++)
                shadow_reg[i] <= '0;
            active_reg   <= '0;
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
            pending_reg  <= 1'b0;
            valid_reg    <= 1'b0;
            update_reg   <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            rd_valid_reg <= cfg_bus.config_read;
            if (cfg_bus.config_read)
                rd_data_reg <= rd_mux;

            if (cfg_bus.config_write && is_word)
                shadow_reg[widx] <= wr_word;

            // Copy uses the pre-edge shadow; a COMMIT on the copy edge re-arms.
            update_reg <= do_copy;
            if (do_copy) begin
                active_reg <= shadow_flat;
                valid_reg  <= 1'b1;
            end
            if (cfg_bus.config_write && is_commit)
                pending_reg <= 1'b1;
            else if (do_copy)
                pending_reg <= 1'b0;

            if ((cfg_bus.config_write || cfg_bus.config_read) && is_oor)
                err_reg <= 1'b1;
            else if (cfg_bus.config_write && is_status
                     && cfg_bus.config_config_data[STAT_ERR])
                err_reg <= 1'b0;
        end
    end

    assign cfg_bus.config_rd_data  = rd_data_reg;
    assign cfg_bus.config_rd_valid = rd_valid_reg;
    assign config_memory_size_550  = active_reg;
    assign cfg_valid               = valid_reg;
    assign cfg_update              = update_reg;
    assign cfg_err                 = err_reg;

endmodule

// File: tb/tb_lake_cfg_loader.sv
// Directed bench for lake_cfg_loader: a bit-level reference model of the
// shadow/active/status rules checked every cycle, plus literal spot checks.
module tb_lake_cfg_loader;
    import lake_cfg_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stall = 1'b0;
    logic [CFG_WIDTH-1:0] active_out;
    logic valid_out, update_out, err_out;

    int compared = 0;
    int mismatched = 0;

    lake_cfg_if cif ();

    lake_cfg_loader dut (
        .clk                    (clk),
        .rst                    (rst),
        .stall                  (stall),
        .cfg_bus                (cif),
        .config_memory_size_550 (active_out),
        .cfg_valid              (valid_out),
        .cfg_update             (update_out),
        .cfg_err                (err_out)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0]          m_shadow [18];
    logic [CFG_WIDTH-1:0] m_active;
    logic [31:0]          m_rd_data;
    logic                 m_rd_valid, m_pending, m_valid, m_update, m_err;
    logic [31:0]          t_rd;
    logic                 t_copy;
    int                   t_addr;

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 18; k++) m_shadow[k] = 0;
            m_active = '0; m_rd_data = 0; m_rd_valid = 0;
            m_pending = 0; m_valid = 0; m_update = 0; m_err = 0;
        end else begin
            t_addr = (cif.config_config_addr > 32'd1000) ? 1000 : int'(cif.config_config_addr);
            t_rd = 0;
            if (t_addr < 18) t_rd = m_shadow[t_addr];
            else if (t_addr == 19) t_rd = {29'd0, m_valid, m_err, m_pending};
            m_rd_valid = cif.config_read;
            if (cif.config_read) m_rd_data = t_rd;

            t_copy = m_pending && !stall;
            m_update = t_copy;
            if (t_copy) begin
                for (int b = 0; b < CFG_WIDTH; b++) m_active[b] = m_shadow[b / 32][b % 32];
                m_valid = 1;
                m_pending = 0;
            end
            if (cif.config_write && t_addr == 18) m_pending = 1;

            if ((cif.config_write || cif.config_read) && t_addr > 19) m_err = 1;
            else if (cif.config_write && t_addr == 19 && cif.config_config_data[1]) m_err = 0;

            if (cif.config_write && t_addr < 18)
                m_shadow[t_addr] = (t_addr == 17) ? (cif.config_config_data & 32'h3F)
                                                  : cif.config_config_data;
        end
    end

    always @(negedge clk) begin
        compared++;
        if (cif.config_rd_valid !== m_rd_valid) begin
            mismatched++;
            $display("FAIL rd_valid: got %0b want %0b at %0t", cif.config_rd_valid, m_rd_valid, $time);
        end
        if (m_rd_valid) begin
            compared++;
            if (cif.config_rd_data !== m_rd_data) begin
                mismatched++;
                $display("FAIL rd_data: got %08h want %08h at %0t", cif.config_rd_data, m_rd_data, $time);
            end
        end
        compared++;
        if (active_out !== m_active) begin
            mismatched++;
            $display("FAIL active: got %h want %h", active_out, m_active);
        end
        compared++;
        if ({valid_out, update_out, err_out} !== {m_valid, m_update, m_err}) begin
            mismatched++;
            $display("FAIL flags(valid,update,err): got %03b want %03b at %0t",
                     {valid_out, update_out, err_out}, {m_valid, m_update, m_err}, $time);
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end else
            $display("ok   %s = %0h", name, got);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        cif.config_write = 1; cif.config_config_addr = a; cif.config_config_data = d;
        tick();
        cif.config_write = 0;
        $display("wr   addr=%0d data=%08h", a, d);
    endtask

    task automatic rd(input int a, output logic [31:0] d, output logic v);
        cif.config_read = 1; cif.config_config_addr = a;
        tick();
        cif.config_read = 0;
        d = cif.config_rd_data; v = cif.config_rd_valid;
        $display("rd   addr=%0d data=%08h valid=%0b", a, d, v);
    endtask

    logic [31:0] rdat;
    logic        rv;
    int          pulses;
    bit          seen;

    initial begin
        cif.config_write = 0; cif.config_read = 0;
        cif.config_config_addr = 0; cif.config_config_data = 0;
        tick(); tick();
        rst = 0;

        rd(19, rdat, rv);
        check("status_after_reset", rdat, 0);
        for (int k = 0; k < 18; k++) wr(k, k);
        tick();
        check("active_no_commit", active_out[63:0], 0);
        check("valid_no_commit", valid_out, 0);
        wr(18, 0);
        rd(19, rdat, rv);
        check("status_pending", rdat, 32'h1);

        for (int k = 0; k < 18; k++) wr(k, 32'hA5A5_0000 + k);
        wr(18, 0);
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (update_out) pulses++;
        end
        check("active_lo", active_out[31:0], 32'hA5A50000);
        check("active_top", active_out[549:544], 6'h11);
        check("update_pulses", pulses, 1);
        check("valid_after_commit", valid_out, 1);

        stall = 1;
        wr(0, 32'h0000_1234);
        wr(18, 0);
        repeat (10) tick();
        check("active_stalled", active_out[31:0], 32'hA5A50000);
        rd(19, rdat, rv);
        check("status_stalled", rdat, 32'h5);
        stall = 0;
        seen = 0;
        for (int c = 0; c < 5 && !seen; c++) begin
            tick();
            if (update_out) seen = 1;
        end
        check("update_after_unstall", seen, 1);
        check("active_after_unstall", active_out[31:0], 32'h1234);

        wr(3, 32'hDEADBEEF);
        rd(3, rdat, rv);
        check("rd_word3", rdat, 32'hDEADBEEF);
        check("rd_word3_valid", rv, 1);
        wr(17, 32'hFFFFFFFF);
        rd(17, rdat, rv);
        check("rd_word17", rdat, 32'h3F);

        wr(4, 32'h11);
        cif.config_read = 1; cif.config_write = 1;
        cif.config_config_addr = 4; cif.config_config_data = 32'h22;
        tick();
        cif.config_read = 0; cif.config_write = 0;
        check("rd_during_wr", cif.config_rd_data, 32'h11);
        rd(4, rdat, rv);
        check("rd_after_wr", rdat, 32'h22);

        wr(25, 32'hFFFF_FFFF);
        check("err_oor_write", err_out, 1);
        rd(30, rdat, rv);
        check("rd_oor_data", rdat, 0);
        check("rd_oor_valid", rv, 1);
        wr(19, 32'h2);
        check("err_cleared", err_out, 0);

        stall = 1;
        wr(18, 0);
        for (int k = 0; k <= 5; k++) wr(k, 32'h5500 + k);
        rst = 1; tick(); rst = 0;
        check("pending_cleared", m_pending, 0);
        rd(19, rdat, rv);
        check("status_after_rst", rdat, 0);
        stall = 0;
        wr(18, 0);
        tick();
        check("active_zero_lo", active_out[63:0], 0);
        check("active_zero_top", active_out[549:486], 0);
        check("valid_zero_commit", valid_out, 1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
